// File: rtl/instr_prefetch_queue_pkg.sv
// Shared constants and types for the instruction prefetch queue:
// bubble encoding, prefetch FSM state codes and the FIFO entry layout.
package instr_prefetch_queue_pkg;

    localparam logic [0:31] NOP_WORD = 32'h0000_0015;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY   = 2'd1;
    localparam logic [1:0] ST_SQUASH = 2'd2;

    typedef struct packed {
        logic [0:31] instr;
        logic [0:31] pc;
    } fifo_entry_t;

    // Sequential fetch advance; wraps silently at 2^32.
    function automatic logic [0:31] next_pc(input logic [0:31] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// Instruction-memory request/acknowledge bus between the prefetch queue
// (master) and the instruction memory (slave).
interface instr_prefetch_queue_if;
    logic        imem_req;
    logic [0:31] imem_addr;
    logic        imem_ack;
    logic [0:31] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/instr_prefetch_queue_prefetch_fifo.sv
// Depth-entry FIFO of {instruction, pc} pairs with flush; flush overrides
// push and pop, and pop of an empty FIFO is ignored.
module prefetch_fifo
    import instr_prefetch_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        push,
    input  fifo_entry_t push_data,
    input  logic        pop,
    output fifo_entry_t head,
    output logic [0:AW] count,
    output logic        empty
);

    localparam int              ONE     = 1;
    localparam logic [AW-1:0]   PTR_ONE = ONE[AW-1:0];
    localparam logic [0:AW]     CNT_ONE = ONE[AW:0];
    localparam logic [0:AW]     FULL    = DEPTH[AW:0];

    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [0:AW]   count_r;
    fifo_entry_t   mem_r [DEPTH];
    logic          do_push_s;
    logic          do_pop_s;

    // Qualify push/pop against occupancy.
    always_comb begin
        do_push_s = push & (count_r != FULL);
        do_pop_s  = pop & (count_r != {(AW+1){1'b0}});
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= {(AW+1){1'b0}};
        end else if (flush) begin
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) tail_r <= tail_r + PTR_ONE;
            if (do_pop_s)  head_r <= head_r + PTR_ONE;
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= 64'h0;
        end else if (do_push_s && !flush) begin
            mem_r[tail_r] <= push_data;
        end
    end

    assign head  = mem_r[head_r];
    assign count = count_r;
    assign empty = (count_r == {(AW+1){1'b0}});

endmodule

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetcher: one outstanding memory request at a time,
// responses buffered with their PCs, flushed and restarted on redirect.
module instr_prefetch_queue
    import instr_prefetch_queue_pkg::*;
#(
    parameter  logic [0:31] InitAddress = 32'h0,
    parameter  int          Depth       = 4,
    localparam int          AW          = $clog2(Depth)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          redirect,
    input  logic [0:31]                   redirect_pc,
    input  logic                          deq,
    instr_prefetch_queue_if.master        imem,
    output logic [0:31]                   Instruction,
    output logic [0:31]                   InstrPC,
    output logic                          valid,
    output logic [0:AW]                   count
);

    localparam logic [AW+1:0] DEPTH_W = Depth[AW+1:0];

    logic [1:0]   state_r, state_nx_s;
    logic [0:31]  fpc_r, fpc_nx_s;
    logic [0:31]  req_addr_r, req_addr_nx_s;
    logic [0:31]  last_pc_r;
    logic         push_s, pop_eff_s, busy_s, empty_s;
    logic         space_s, space_after_s;
    logic [AW+1:0] occ_s;
    logic [0:AW]  count_s;
    fifo_entry_t  head_s;

    prefetch_fifo #(.DEPTH(Depth)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (push_s),
        .push_data ('{instr: imem.imem_rdata, pc: req_addr_r}),
        .pop       (deq & ~redirect),
        .head      (head_s),
        .count     (count_s),
        .empty     (empty_s)
    );

    // The in-flight request reserves a FIFO slot before its data returns.
    always_comb begin
        busy_s        = (state_r != ST_IDLE);
        pop_eff_s     = deq & ~empty_s;
        occ_s         = {1'b0, count_s} + {{(AW+1){1'b0}}, busy_s};
        space_s       = occ_s < DEPTH_W;
        space_after_s = (occ_s - {{(AW+1){1'b0}}, pop_eff_s}) < DEPTH_W;
    end

    // Prefetch FSM next-state.
    always_comb begin
        state_nx_s    = state_r;
        fpc_nx_s      = fpc_r;
        req_addr_nx_s = req_addr_r;
        push_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (redirect) begin
                    fpc_nx_s = redirect_pc;
                end else if (space_s) begin
                    req_addr_nx_s = fpc_r;
                    fpc_nx_s      = next_pc(fpc_r);
                    state_nx_s    = ST_BUSY;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (redirect) begin
                    fpc_nx_s   = redirect_pc;
                    state_nx_s = imem.imem_ack ? ST_IDLE : ST_SQUASH;
                end else if (imem.imem_ack) begin
                    push_s = 1'b1;
                    if (space_after_s) begin
                        req_addr_nx_s = fpc_r;
                        fpc_nx_s      = next_pc(fpc_r);
                        state_nx_s    = ST_BUSY;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else begin
                    state_nx_s = ST_BUSY;
                end
            end
            ST_SQUASH: begin
                if (redirect) fpc_nx_s = redirect_pc;
                else          fpc_nx_s = fpc_r;
                if (imem.imem_ack) state_nx_s = ST_IDLE;
                else               state_nx_s = ST_SQUASH;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State, fetch PC, request address and held head PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            fpc_r      <= InitAddress;
            req_addr_r <= InitAddress;
            last_pc_r  <= 32'h0;
        end else begin
            state_r    <= state_nx_s;
            fpc_r      <= fpc_nx_s;
            req_addr_r <= req_addr_nx_s;
            last_pc_r  <= empty_s ? last_pc_r : head_s.pc;
        end
    end

    assign imem.imem_req  = (state_r == ST_BUSY) || (state_r == ST_SQUASH);
    assign imem.imem_addr = req_addr_r;
    assign Instruction    = empty_s ? NOP_WORD : head_s.instr;
    assign InstrPC        = empty_s ? last_pc_r : head_s.pc;
    assign valid          = ~empty_s;
    assign count          = count_s;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed and randomized bench for instr_prefetch_queue against a
// transaction-level model (pending request + queue of fetched words).
module tb_instr_prefetch_queue;

    localparam logic [31:0] INIT  = 32'h0000_0100;
    localparam int          DEPTH = 4;
    localparam logic [31:0] MASK  = 32'hAAAA_0000;
    localparam logic [31:0] NOP   = 32'h0000_0015;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [0:31] redirect_pc = 32'h0;
    logic        deq = 1'b0;
    logic [0:31] Instruction, InstrPC;
    logic        valid;
    logic [0:2]  count;

    instr_prefetch_queue_if bus ();

    instr_prefetch_queue #(.InitAddress(INIT), .Depth(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .deq         (deq),
        .imem        (bus),
        .Instruction (Instruction),
        .InstrPC     (InstrPC),
        .valid       (valid),
        .count       (count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: queue of {word, pc}, next fetch PC, one pending request.
    logic [63:0] mq[$];
    logic [31:0] m_fpc = INIT;
    logic        m_pend = 1'b0;
    logic [31:0] m_addr = 32'h0;
    logic        m_sq = 1'b0;
    logic [31:0] m_last = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fpc  = INIT;
        m_pend = 1'b0;
        m_addr = 32'h0;
        m_sq   = 1'b0;
        m_last = 32'h0;
    endtask

    task automatic check_outputs();
        chk("imem_req", {31'h0, bus.imem_req}, {31'h0, m_pend});
        if (m_pend) chk("imem_addr", bus.imem_addr, m_addr);
        chk("valid", {31'h0, valid}, {31'h0, (mq.size() > 0)});
        chk("count", {29'h0, count}, mq.size());
        if (mq.size() > 0) begin
            chk("Instruction", Instruction, mq[0][63:32]);
            chk("InstrPC", InstrPC, mq[0][31:0]);
            m_last = mq[0][31:0];
        end else begin
            chk("Instruction_nop", Instruction, NOP);
            chk("InstrPC_hold", InstrPC, m_last);
        end
    endtask

    // One clock cycle: drive inputs, advance the model at the edge, compare.
    task automatic step(input logic rd, input logic [31:0] rpc, input logic dq, input logic ak);
        logic ak_e, popf, issue;
        int   sz0;
        ak_e = ak & m_pend;
        redirect = rd;
        redirect_pc = rpc;
        deq = dq;
        bus.imem_ack = ak_e;
        bus.imem_rdata = m_addr ^ MASK;
        @(posedge clk);
        sz0 = mq.size();
        popf = dq && (sz0 > 0) && !rd;
        issue = 1'b0;
        if (rd) begin
            mq.delete();
            m_fpc = rpc;
            if (m_pend && ak_e) begin
                m_pend = 1'b0;
                m_sq = 1'b0;
            end else if (m_pend) begin
                m_sq = 1'b1;
            end
        end else begin
            if (popf) void'(mq.pop_front());
            if (!m_pend) begin
                issue = (sz0 < DEPTH);
            end else if (ak_e) begin
                m_pend = 1'b0;
                if (m_sq) begin
                    m_sq = 1'b0;
                end else begin
                    mq.push_back({m_addr ^ MASK, m_addr});
                    issue = (mq.size() < DEPTH);
                end
            end
        end
        if (issue) begin
            m_pend = 1'b1;
            m_addr = m_fpc;
            m_fpc  = m_fpc + 32'd4;
        end
        #1;
        check_outputs();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req"}, {31'h0, bus.imem_req}, 32'h0);
        chk({tag, "_valid"}, {31'h0, valid}, 32'h0);
        chk({tag, "_count"}, {29'h0, count}, 32'h0);
        chk({tag, "_instr"}, Instruction, NOP);
        chk({tag, "_pc"}, InstrPC, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect = 1'b0;
        deq = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0;
        @(posedge clk);
        #1;
        model_reset();
        check_reset_values("reset");
        reset = 1'b0;
    endtask

    initial begin
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0;

        // Streaming with ack and deq every cycle.
        do_reset();
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("first_addr", bus.imem_addr, INIT);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            chk("seq_addr", bus.imem_addr, INIT + 32'd4 + 32'(4 * i));
            chk("count_le1", {31'h0, (count <= 3'd1)}, 32'h1);
        end

        // Fill with no deq: four requests then stall.
        do_reset();
        step(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("full_count", {29'h0, count}, 32'd4);
        chk("full_req", {31'h0, bus.imem_req}, 32'h0);
        chk("full_head", InstrPC, 32'h100);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("refill_addr", bus.imem_addr, 32'h110);

        // Redirect with outstanding request, ack delayed three cycles.
        step(1'b1, 32'h400, 1'b0, 1'b0);
        chk("redir_flush", {29'h0, count}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b0);
            chk("squash_hold", bus.imem_addr, 32'h110);
        end
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("squash_drop", {31'h0, valid}, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("redir_addr", bus.imem_addr, 32'h400);

        // Redirect coinciding with ack and deq.
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 32'h480, 1'b1, 1'b1);
        chk("redir_ack_count", {29'h0, count}, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("redir_ack_addr", bus.imem_addr, 32'h480);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("full_again", {29'h0, count}, 32'd4);
        step(1'b1, 32'h700, 1'b1, 1'b0);
        chk("redir_full_count", {29'h0, count}, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("redir_full_addr", bus.imem_addr, 32'h700);

        // Back-to-back redirects while squashing.
        step(1'b1, 32'h500, 1'b0, 1'b0);
        step(1'b1, 32'h600, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("double_redir_addr", bus.imem_addr, 32'h600);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("double_redir_head", InstrPC, 32'h600);

        // Asynchronous reset mid-request with an ack during reset.
        bus.imem_ack = 1'b1;
        reset = 1'b1;
        #1;
        model_reset();
        check_reset_values("async");
        @(posedge clk);
        #1;
        check_reset_values("async_hold");
        reset = 1'b0;
        bus.imem_ack = 1'b0;
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("post_reset_addr", bus.imem_addr, INIT);

        // Fetch PC wrap at 2^32.
        step(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("wrap_count", {29'h0, count}, 32'd4);
        for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("wrap_head", InstrPC, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rpc;
            rpc = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'h0000_000C);
            step(($urandom_range(0, 99) < 8), rpc,
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 99) < 60));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
